// File: rtl/button_debounce_array.sv
// Per-channel button debouncer: synchroniser, 4-state stable-count FSM,
// registered level/press/release outputs and a one-shot long-press pulse.
module button_debounce_array #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STABLE_CNT  = 16,
  parameter int unsigned LONG_CNT    = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i_btn,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic [N_CH-1:0] o_long
);

  localparam int unsigned CNT_W  = $clog2(STABLE_CNT + 1);
  localparam int unsigned HOLD_W = (LONG_CNT == 0) ? 1 : $clog2(LONG_CNT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CNT);
  localparam bit                LONG_EN  = (LONG_CNT != 0);
  localparam bit                SKIP_CHK = (STABLE_CNT == 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RISE_CHK = 2'd1,
    PRESSED  = 2'd2,
    FALL_CHK = 2'd3
  } state_t;

  for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_nxt;
    logic [CNT_W-1:0]       cnt_q, cnt_nxt;
    logic [HOLD_W-1:0]      hold_q, hold_nxt;
    logic                   level_q, press_q, release_q, long_q;
    logic                   level_nxt, long_nxt, holding;

    // Metastability synchroniser; only its last stage feeds the FSM
    always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], i_btn[g]};
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      hold_nxt  = hold_q;
      long_nxt  = 1'b0;
      level_nxt = 1'b0;
      holding   = (state_q == PRESSED) || (state_q == FALL_CHK);

      case (state_q)
        IDLE: begin
          if (s) begin
            if (SKIP_CHK) begin
              state_nxt = PRESSED;
              cnt_nxt   = '0;
            end else begin
              state_nxt = RISE_CHK;
              cnt_nxt   = CNT_W'(1);
            end
          end
        end
        RISE_CHK: begin
          if (!s) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt_q >= CNT_LAST) begin
            state_nxt = PRESSED;
            cnt_nxt   = '0;
          end else if (cnt_q != CNT_MAX) begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!s) begin
            if (SKIP_CHK) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end else begin
              state_nxt = FALL_CHK;
              cnt_nxt   = CNT_W'(1);
            end
          end
        end
        FALL_CHK: begin
          if (s) begin
            state_nxt = PRESSED;
            cnt_nxt   = '0;
          end else if (cnt_q >= CNT_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt_q != CNT_MAX) begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase

      level_nxt = (state_nxt == PRESSED) || (state_nxt == FALL_CHK);

      // Hold time runs through release bounces; restarts only on a fresh press
      if (holding) begin
        if (hold_q != HOLD_MAX) hold_nxt = hold_q + HOLD_W'(1);
      end else if (state_nxt == PRESSED) begin
        hold_nxt = '0;
      end

      long_nxt = LONG_EN && holding && level_nxt &&
                 (hold_q != HOLD_MAX) && (hold_nxt == HOLD_MAX);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        hold_q    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        state_q   <= state_nxt;
        cnt_q     <= cnt_nxt;
        hold_q    <= hold_nxt;
        level_q   <= level_nxt;
        press_q   <= level_nxt & ~level_q;
        release_q <= ~level_nxt & level_q;
        long_q    <= long_nxt;
      end
    end

    assign o_level[g]   = level_q;
    assign o_press[g]   = press_q;
    assign o_release[g] = release_q;
    assign o_long[g]    = long_q;
  end

endmodule

// File: tb/tb_button_debounce_array.sv
// Bench for button_debounce_array: directed scenarios plus random bouncing,
// checked every cycle against a run-length/timestamp reference model.
module tb_button_debounce_array;

  localparam int unsigned SYNC   = 2;
  localparam int unsigned STAB_A = 16;
  localparam int unsigned LONG_A = 50;
  localparam int unsigned STAB_B = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_a = '0;
  logic [3:0] lvl_a, prs_a, rel_a, lng_a;
  logic [0:0] btn_b = '0;
  logic [0:0] lvl_b, prs_b, rel_b, lng_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  button_debounce_array #(.N_CH(4), .SYNC_STAGES(SYNC), .STABLE_CNT(STAB_A), .LONG_CNT(LONG_A)) u_dut_a (
    .clk(clk), .rst(rst), .i_btn(btn_a),
    .o_level(lvl_a), .o_press(prs_a), .o_release(rel_a), .o_long(lng_a)
  );

  button_debounce_array #(.N_CH(1), .SYNC_STAGES(SYNC), .STABLE_CNT(STAB_B), .LONG_CNT(0)) u_dut_b (
    .clk(clk), .rst(rst), .i_btn(btn_b),
    .o_level(lvl_b), .o_press(prs_b), .o_release(rel_b), .o_long(lng_b)
  );

  // Reference model: a level flips once the synchronised input has disagreed
  // with it for STABLE consecutive samples; long fires LONG edges after press.
  logic [3:0] qa[$];
  logic [3:0] qb[$];
  logic       m_lvl  [2][4];
  logic       last_s [2][4];
  int         run_len[2][4];
  int         press_t[2][4];
  logic [3:0] e_lvl[2], e_prs[2], e_rel[2], e_lng[2];
  int         tcyc = 0;

  task automatic model_edge(input logic r, input logic [3:0] ina, input logic [3:0] inb);
    logic [3:0] seen[2];
    logic s, old, nw;
    int stab, lng;
    if (r) begin
      qa.delete(); qb.delete();
      repeat (SYNC) begin qa.push_back(4'h0); qb.push_back(4'h0); end
      for (int i = 0; i < 2; i++) begin
        e_lvl[i] = '0; e_prs[i] = '0; e_rel[i] = '0; e_lng[i] = '0;
        for (int c = 0; c < 4; c++) begin
          m_lvl[i][c] = 1'b0; last_s[i][c] = 1'b0;
          run_len[i][c] = 0; press_t[i][c] = -1000000;
        end
      end
    end else begin
      seen[0] = qa.pop_front(); qa.push_back(ina);
      seen[1] = qb.pop_front(); qb.push_back(inb);
      for (int i = 0; i < 2; i++) begin
        stab = (i == 0) ? int'(STAB_A) : int'(STAB_B);
        lng  = (i == 0) ? int'(LONG_A) : 0;
        for (int c = 0; c < 4; c++) begin
          s = seen[i][c];
          if (s == last_s[i][c]) begin
            if (run_len[i][c] < 1000000) run_len[i][c]++;
          end else begin
            run_len[i][c] = 1;
          end
          last_s[i][c] = s;
          old = m_lvl[i][c];
          nw  = (s != old && run_len[i][c] >= stab) ? s : old;
          if (nw && !old) press_t[i][c] = tcyc;
          e_prs[i][c] = nw & ~old;
          e_rel[i][c] = ~nw & old;
          e_lng[i][c] = (lng != 0) && old && nw && (tcyc - press_t[i][c] == lng);
          e_lvl[i][c] = nw;
          m_lvl[i][c] = nw;
        end
      end
    end
    tcyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, tcyc);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] a, input logic b);
    rst = r; btn_a = a; btn_b[0] = b;
    @(posedge clk);
    model_edge(r, a, {3'b000, b});
    #1;
    chk("lvl_a", 32'(lvl_a), 32'(e_lvl[0]));
    chk("prs_a", 32'(prs_a), 32'(e_prs[0]));
    chk("rel_a", 32'(rel_a), 32'(e_rel[0]));
    chk("lng_a", 32'(lng_a), 32'(e_lng[0]));
    chk("lvl_b", 32'(lvl_b), 32'(e_lvl[1][0]));
    chk("prs_b", 32'(prs_b), 32'(e_prs[1][0]));
    chk("rel_b", 32'(rel_b), 32'(e_rel[1][0]));
    chk("lng_b", 32'(lng_b), 32'(e_lng[1][0]));
  endtask

  initial begin
    int pedge, redge, ledge, np, nr, nl, lvl_seen;
    logic [3:0] cur;
    logic       curb;

    // Single high-level press on ch0: accepted after edge 18
    step(1'b1, 4'h0, 1'b0);
    pedge = 0; np = 0;
    for (int k = 1; k <= 30; k++) begin
      step(1'b0, 4'h1, 1'b0);
      if (prs_a[0]) begin np++; pedge = k; end
    end
    chk("r033_press_edge", 32'(pedge), 32'd18);
    chk("r033_press_count", 32'(np), 32'd1);
    chk("r033_level", 32'(lvl_a), 32'h1);

    // ch1 toggling every 5 cycles never settles long enough
    step(1'b1, 4'h0, 1'b0);
    np = 0; nr = 0; lvl_seen = 0;
    for (int k = 0; k < 200; k++) begin
      step(1'b0, ((k / 5) % 2 == 1) ? 4'h2 : 4'h0, 1'b0);
      if (prs_a[1]) np++;
      if (rel_a[1]) nr++;
      if (lvl_a[1]) lvl_seen++;
    end
    chk("r034_press_count", 32'(np), 32'd0);
    chk("r034_release_count", 32'(nr), 32'd0);
    chk("r034_level_high", 32'(lvl_seen), 32'd0);

    // Long hold on ch2 then release
    step(1'b1, 4'h0, 1'b0);
    pedge = 0; redge = 0; ledge = 0; nl = 0; nr = 0;
    for (int k = 1; k <= 140; k++) begin
      step(1'b0, (k <= 100) ? 4'h4 : 4'h0, 1'b0);
      if (prs_a[2]) pedge = k;
      if (lng_a[2]) begin ledge = k; nl++; end
      if (rel_a[2]) begin redge = k; nr++; end
    end
    chk("r035_press_edge", 32'(pedge), 32'd18);
    chk("r035_long_edge", 32'(ledge), 32'd68);
    chk("r035_long_count", 32'(nl), 32'd1);
    chk("r035_release_edge", 32'(redge), 32'd118);
    chk("r035_release_count", 32'(nr), 32'd1);

    // Short hold on ch3: release before the long threshold
    step(1'b1, 4'h0, 1'b0);
    pedge = 0; redge = 0; nl = 0; np = 0; nr = 0;
    for (int k = 1; k <= 70; k++) begin
      step(1'b0, (k <= 30) ? 4'h8 : 4'h0, 1'b0);
      if (prs_a[3]) begin pedge = k; np++; end
      if (rel_a[3]) begin redge = k; nr++; end
      if (lng_a[3]) nl++;
    end
    chk("r036_press_edge", 32'(pedge), 32'd18);
    chk("r036_release_edge", 32'(redge), 32'd48);
    chk("r036_counts", 32'({np[7:0], nr[7:0]}), 32'h0101);
    chk("r036_long_count", 32'(nl), 32'd0);

    // All channels together, then reset mid-press and re-acceptance
    step(1'b1, 4'h0, 1'b0);
    pedge = 0;
    for (int k = 1; k <= 25; k++) begin
      step(1'b0, 4'hf, 1'b0);
      if (prs_a == 4'hf) pedge = k;
    end
    chk("r037_all_press_edge", 32'(pedge), 32'd18);
    step(1'b1, 4'hf, 1'b0);
    chk("r037_reset_outputs", 32'({lvl_a, prs_a, rel_a, lng_a}), 32'h0);
    pedge = 0; nr = 0;
    for (int k = 1; k <= 25; k++) begin
      step(1'b0, 4'hf, 1'b0);
      if (rel_a != 4'h0) nr++;
      if (prs_a == 4'hf) pedge = k;
    end
    chk("r037_no_release", 32'(nr), 32'd0);
    chk("r031_repress_edge", 32'(pedge), 32'd18);

    // STABLE_CNT=1 instance, single-cycle pulse
    step(1'b1, 4'h0, 1'b0);
    pedge = 0; redge = 0;
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 4'h0, (k == 1));
      if (prs_b[0]) pedge = k;
      if (rel_b[0]) redge = k;
    end
    chk("r038_press_edge", 32'(pedge), 32'd3);
    chk("r038_release_edge", 32'(redge), 32'd4);

    // Random bouncing with varied flip rates and occasional reset
    step(1'b1, 4'h0, 1'b0);
    cur = 4'h0; curb = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(39, 0) == 0) cur[0] = ~cur[0];
      if ($urandom_range(7, 0)  == 0) cur[1] = ~cur[1];
      if ($urandom_range(24, 0) == 0) cur[2] = ~cur[2];
      if ($urandom_range(59, 0) == 0) cur[3] = ~cur[3];
      if ($urandom_range(2, 0)  == 0) curb = ~curb;
      step(($urandom_range(699, 0) == 0), cur, curb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
